// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, R/W encoding and the converter address.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_RX_BYTE,
        ST_ACK_RX,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_WAIT
    } i2c_state_e;

    localparam logic       I2C_RW_READ  = 1'b1;
    localparam logic       I2C_RW_WRITE = 1'b0;
    localparam logic [6:0] CONV_ADDR    = 7'h48;

endpackage

// File: rtl/i2c_target_line_filter.sv
// Synchronizer + glitch filter + edge pulses for one open-drain I2C line.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int unsigned           CNT_W    = 3;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Level only follows the synchronized input after FILTER_LEN equal samples;
    // edge pulses coincide with the level update.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync[1];
                rise  <= sync[1];
                fall  <= ~sync[1];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target emulating the converter: address match, ACK, byte RX and handshake-fed TX.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  ADDR       = CONV_ADDR,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy
);
    localparam int unsigned BIT_W = 3;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk     (clk),
        .reset   (reset),
        .line_in (scl_in),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk     (clk),
        .reset   (reset),
        .line_in (sda_in),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    i2c_state_e       state;
    logic [BIT_W-1:0] bit_cnt;
    logic [7:0]       shift;
    logic             rw;
    logic             pend;
    logic             first_byte;

    logic       start_c, stop_c, last_bit_c;
    logic [7:0] shift_in_c;

    assign start_c    = sda_fall & scl_lvl;
    assign stop_c     = sda_rise & scl_lvl;
    assign last_bit_c = (bit_cnt == BIT_W'(7));
    assign shift_in_c = {shift[6:0], sda_lvl};

    // pend marks "byte/ack phase complete, act on the next SCL fall".
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            rw         <= I2C_RW_WRITE;
            pend       <= 1'b0;
            first_byte <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            tx_req     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            tx_req   <= 1'b0;
            if (start_c) begin
                state      <= ST_ADDR;
                bit_cnt    <= '0;
                pend       <= 1'b0;
                first_byte <= 1'b1;
                sda_oe     <= 1'b0;
                busy       <= 1'b0;
            end else if (stop_c) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
                pend    <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_WAIT: sda_oe <= 1'b0;
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift   <= shift_in_c;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (last_bit_c) begin
                                rw   <= sda_lvl;
                                pend <= 1'b1;
                            end
                        end else if (scl_fall && pend) begin
                            pend <= 1'b0;
                            if (shift[7:1] == ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                state  <= ST_ACK_ADDR;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_ACK_ADDR: begin
                        if (scl_rise && rw == I2C_RW_READ) begin
                            tx_req <= 1'b1;
                        end
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw == I2C_RW_READ) begin
                                shift  <= tx_data;
                                sda_oe <= ~tx_data[7];
                                state  <= ST_TX_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_RX_BYTE;
                            end
                        end
                    end
                    ST_RX_BYTE: begin
                        if (scl_rise) begin
                            shift   <= shift_in_c;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (last_bit_c) begin
                                rx_data    <= shift_in_c;
                                rx_valid   <= 1'b1;
                                rx_first   <= first_byte;
                                first_byte <= 1'b0;
                                pend       <= 1'b1;
                            end
                        end else if (scl_fall && pend) begin
                            pend   <= 1'b0;
                            sda_oe <= 1'b1;
                            state  <= ST_ACK_RX;
                        end
                    end
                    ST_ACK_RX: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_RX_BYTE;
                        end
                    end
                    ST_TX_BYTE: begin
                        if (scl_fall) begin
                            if (last_bit_c) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_TX_ACK;
                            end else begin
                                shift   <= {shift[6:0], 1'b0};
                                sda_oe  <= ~shift[6];
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_lvl) begin
                                tx_req <= 1'b1;
                                pend   <= 1'b1;
                            end else begin
                                state <= ST_WAIT;
                            end
                        end else if (scl_fall && pend) begin
                            pend    <= 1'b0;
                            shift   <= tx_data;
                            sda_oe  <= ~tx_data[7];
                            bit_cnt <= '0;
                            state   <= ST_TX_BYTE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Synthesizable I2C target (responder), the bus end opposite the I2C controllers that drive the display and converter lines.
- Used as an on-chip or bench-side emulator of the ADC/DAC converter, so that controller transactions on scl_converter/sda_converter are closed-loop checked.
- Decodes START/STOP, matches a 7-bit address, ACKs, delivers written bytes, and serves read bytes through a request/data handshake.
- Standard mode (100 kHz) under a 50 MHz clk.

Parameters:
- ADDR, 7'h48, own 7-bit target address.
- FILTER_LEN, 3, consecutive equal samples required before a filtered SCL/SDA level changes (range 1..7).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL line level (asynchronous).
- sda_in  in  1  raw SDA line level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain), 0 = release.
- rx_data  out  8  last byte written by controller.
- rx_valid  out  1  one-cycle pulse, rx_data new.
- rx_first  out  1  qualifies rx_valid: first data byte after address (register pointer).
- tx_req  out  1  one-cycle pulse, next read byte needed.
- tx_data  in  8  read byte; must be stable from 2 cycles after tx_req until the next SCL fall.
- busy  out  1  high from address match until STOP / repeated START.

Behaviour:
- Reset: all outputs 0, rx_data=8'h00, state IDLE. Effective the cycle after reset is sampled high.
- Reset mid-transaction releases SDA immediately; the block then ignores the bus until a fresh START.
- Input path: 2-flop synchronizer, then FILTER_LEN glitch filter, then edge detect. Filtered edges lag raw edges by 2+FILTER_LEN cycles. All actions below key off filtered edges.
- START: SDA fall while SCL high. From any state (repeated START included) go to ADDR with bit count 0 and sda_oe=0.
- STOP: SDA rise while SCL high. From any state go to IDLE, sda_oe=0, busy=0.
- START/STOP detection has priority over data sampling in the same cycle.
- Data sampling: on SCL rise, MSB first.
- SDA drive changes only on SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (address + R/W).
    - Address match: on the next SCL fall set sda_oe=1 and busy=1. Go to ACK_ADDR.
    - Mismatch: go to IDLE, never drive.
  - ACK_ADDR: on SCL rise, if R/W=1 pulse tx_req. On SCL fall release SDA; go to RX_BYTE (W) or TX_BYTE (R). For R, load tx_data into the shift register and drive bit7 on that same fall.
  - RX_BYTE: 8 bits.
    - On the 8th rise, pulse rx_valid with rx_data updated; rx_first=1 only for the first byte of the transaction.
    - On the next fall, sda_oe=1 and go to ACK_RX. Every written byte is ACKed (no overflow condition).
  - ACK_RX: release on fall, go to RX_BYTE.
  - TX_BYTE: sda_oe = ~shift[7], shifting on each fall.
    - After the 8th bit's fall, release SDA and go to TX_ACK.
  - TX_ACK: sample the controller ack on rise.
    - 0 (ACK): pulse tx_req and return to TX_BYTE, loading on the next fall.
    - 1 (NACK): go to WAIT.
  - WAIT: sda_oe=0; exit only on STOP or START.
- Bit counter 3 bits, wraps to 0 after each byte.
- R/W latched in ADDR.
- General call (addr 0) is not acknowledged unless ADDR=0.

Decomposition:
- Shared package i2c_pkg:
  - state enumeration (IDLE, ADDR, ACK_ADDR, RX_BYTE, ACK_RX, TX_BYTE, TX_ACK, WAIT);
  - I2C_RW_READ=1, I2C_RW_WRITE=0;
  - default address constant CONV_ADDR=7'h48, shared with the controller blocks.
- Sub-module i2c_line_filter (synchronizer + glitch filter + rise/fall pulses), instantiated once for SCL and once for SDA.

Test Plan:
- Write: START, 0x90, 0x40, 0xA5, STOP at 100 kHz -> ACK on all three bytes; rx_valid twice with 0x40 (rx_first=1) then 0xA5 (rx_first=0); busy 0 after STOP.
- Wrong address: 0x92 -> sda_oe never asserted, no rx_valid, busy stays 0, bus returns to IDLE.
- Read: 0x91, bench returns tx_data 0x3C then 0xC3, controller ACKs byte 1 and NACKs byte 2 -> SDA reads 0x3C and 0xC3, exactly 2 tx_req pulses, sda_oe=0 after the 2nd byte.
- Repeated START: write 0x90,0x00 then Sr 0x91 read one byte (NACK), STOP -> rx_valid once with 0x00 (rx_first=1), then one tx_req, correct R/W switch.
- Glitch: 40 ns low pulse on SCL mid-byte with FILTER_LEN=3 -> ignored; received byte unchanged.
- Reset asserted while driving ACK -> sda_oe=0 next cycle; following bytes ignored until a new START, then a normal write of 0x90,0x11 is ACKed.
